// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with line refill over a req/gnt + streaming-data port.
// Define ICACHE_PERF_EN to compile in the hit/miss counters; otherwise both counter ports read 0.
module icache_dm #(
  parameter int unsigned SETS   = 16,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_valid_o,
  output logic              cpu_stall_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

  state_t state_q, state_d;

  logic [31:0]      data_q [SETS][WORDS];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [SETS-1:0]  valid_q;

  logic [TAG_W-1:0] line_tag_q;
  logic [IDX_W-1:0] line_idx_q;
  logic [OFF_W-1:0] req_off_q;
  logic [OFF_W-1:0] cnt_q;
  logic             flush_pend_q;

  logic [OFF_W-1:0] addr_off;
  logic [IDX_W-1:0] addr_idx;
  logic [TAG_W-1:0] addr_tag;
  logic             hit;
  logic             lookup_hit;
  logic             lookup_miss;
  logic             resp_valid;
  logic             stall;
  logic             fill_last;
  logic [31:0]      rdata_sel;
  logic             unused_addr_bits;

  assign addr_off = cpu_addr_i[2 +: OFF_W];
  assign addr_idx = cpu_addr_i[2 + OFF_W +: IDX_W];
  assign addr_tag = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit       = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign fill_last = mem_rvalid_i && (cnt_q == '1);

  always_comb begin
    state_d     = state_q;
    resp_valid  = 1'b0;
    stall       = 1'b0;
    lookup_hit  = 1'b0;
    lookup_miss = 1'b0;
    rdata_sel   = data_q[addr_idx][addr_off];
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            resp_valid = 1'b1;
            lookup_hit = 1'b1;
          end else begin
            stall       = 1'b1;
            lookup_miss = 1'b1;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_gnt_i) state_d = FILL;
      end
      FILL: begin
        stall = 1'b1;
        if (fill_last) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        rdata_sel  = data_q[line_idx_q][req_off_q];
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are masked while reset is held so they drop without waiting for an edge.
  assign cpu_valid_o = resp_valid && !rst_i;
  assign cpu_stall_o = stall && !rst_i;
  assign cpu_rdata_o = cpu_valid_o ? rdata_sel : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      line_tag_q   <= '0;
      line_idx_q   <= '0;
      req_off_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (flush_i) valid_q <= '0;
          if (lookup_miss) begin
            line_tag_q <= addr_tag;
            line_idx_q <= addr_idx;
            req_off_q  <= addr_off;
            cnt_q      <= '0;
            mem_req_o  <= 1'b1;
            mem_addr_o <= {addr_tag, addr_idx, {(OFF_W + 2){1'b0}}};
          end
        end
        REQ: begin
          if (flush_i) flush_pend_q <= 1'b1;
          if (mem_gnt_i) mem_req_o <= 1'b0;
        end
        FILL: begin
          if (flush_i) flush_pend_q <= 1'b1;
          if (mem_rvalid_i) cnt_q <= cnt_q + OFF_W'(1);
          if (fill_last) valid_q[line_idx_q] <= 1'b1;
        end
        RESP: begin
          // A flush seen during the refill also drops the line just filled.
          if (flush_pend_q || flush_i) valid_q <= '0;
          flush_pend_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == FILL && mem_rvalid_i) begin
      data_q[line_idx_q][cnt_q] <= mem_rdata_i;
      if (cnt_q == '1) tag_q[line_idx_q] <= line_tag_q;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = lookup_hit;
  assign hit_cnt_o   = '0;
  assign miss_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm (SETS=16, WORDS=4, ADDR_W=32).
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_valid;
  logic        cpu_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_dm #(.SETS(16), .WORDS(4), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_rdata_o(cpu_rdata),
    .cpu_valid_o(cpu_valid), .cpu_stall_o(cpu_stall), .flush_i(flush),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full refill with immediate grant and back-to-back words base..base+3; lat counts edges from miss cycle to cpu_valid.
  task automatic refill(input logic [31:0] addr, input logic [31:0] base,
                        output logic [31:0] line_addr, output int lat, output logic [31:0] word);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    #1;
    tick();
    lat = 1;
    while (!mem_req && lat < 20) begin tick(); lat++; end
    line_addr = mem_addr;
    mem_gnt = 1'b1;
    tick(); lat++;
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(i);
      tick(); lat++;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    while (!cpu_valid && lat < 40) begin tick(); lat++; end
    word = cpu_rdata;
    if (!cpu_valid) lat = -1;
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL reset_cpu_valid got %b want 0", cpu_valid); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall got %b want 0", cpu_stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata got %h want 0", cpu_rdata); end
    checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_counters got hit %0d miss %0d want 0 0", hit_cnt, miss_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss();
    int stall_low = 0;
    int early = 0;
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_0108;
    #1;
    checks++; if (cpu_stall !== 1'b1 || cpu_valid !== 1'b0) begin
      errors++; $display("FAIL cold_miss_cycle got stall %b valid %b want 1 0", cpu_stall, cpu_valid); end
    for (int c = 1; c <= 7; c++) begin
      tick();
      mem_gnt = (c == 2);
      mem_rvalid = (c >= 3 && c <= 6);
      mem_rdata  = (c >= 3 && c <= 6) ? 32'hA0 + 32'(c - 3) : 32'h0;
      #1;
      if (c == 1 || c == 2) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0100) begin
          errors++; $display("FAIL cold_req_c%0d got req %b addr %h want 1 00000100", c, mem_req, mem_addr); end
      end
      if (c == 3) begin
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL cold_req_drop got %b want 0", mem_req); end
      end
      if (c < 7 && cpu_stall !== 1'b1) stall_low++;
      if (c < 7 && cpu_valid !== 1'b0) early++;
    end
    checks++; if (stall_low != 0) begin errors++; $display("FAIL cold_stall_hold got %0d low cycles want 0", stall_low); end
    checks++; if (early != 0) begin errors++; $display("FAIL cold_early_valid got %0d cycles want 0", early); end
    checks++; if (cpu_valid !== 1'b1 || cpu_rdata !== 32'hA2 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL cold_resp got valid %b rdata %h stall %b want 1 000000a2 0", cpu_valid, cpu_rdata, cpu_stall); end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    tick();
    cpu_addr = 32'h0000_010C;
    #1;
    checks++; if (cpu_valid !== 1'b1 || cpu_rdata !== 32'hA3 || cpu_stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_hit got valid %b rdata %h stall %b req %b want 1 000000a3 0 0",
                         cpu_valid, cpu_rdata, cpu_stall, mem_req); end
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic test_hit();
    logic [31:0] addrs [2] = '{32'h0000_0100, 32'h0000_0104};
    logic [31:0] exp   [2] = '{32'hA0, 32'hA1};
    for (int i = 0; i < 2; i++) begin
      cpu_req  = 1'b1;
      cpu_addr = addrs[i];
      #1;
      checks++; if (cpu_valid !== 1'b1 || cpu_rdata !== exp[i] || cpu_stall !== 1'b0) begin
        errors++; $display("FAIL hit_%0d got valid %b rdata %h stall %b want 1 %h 0", i, cpu_valid, cpu_rdata, cpu_stall, exp[i]); end
      tick();
      cpu_req = 1'b0;
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp_hit;
    logic [31:0] exp_miss;
`ifdef ICACHE_PERF_EN
    exp_hit = 32'd3; exp_miss = 32'd1;
`else
    exp_hit = 32'd0; exp_miss = 32'd0;
`endif
    #1;
    checks++; if (hit_cnt !== exp_hit) begin errors++; $display("FAIL perf_hit got %0d want %0d", hit_cnt, exp_hit); end
    checks++; if (miss_cnt !== exp_miss) begin errors++; $display("FAIL perf_miss got %0d want %0d", miss_cnt, exp_miss); end
  endtask

  task automatic test_eviction();
    logic [31:0] la;
    int lat;
    logic [31:0] w;
    refill(32'h0000_0500, 32'hB0, la, lat, w);
    checks++; if (la !== 32'h0000_0500 || lat != 6 || w !== 32'hB0) begin
      errors++; $display("FAIL evict_500 got addr %h lat %0d word %h want 00000500 6 000000b0", la, lat, w); end
    refill(32'h0000_0100, 32'hC0, la, lat, w);
    checks++; if (la !== 32'h0000_0100 || lat != 6 || w !== 32'hC0) begin
      errors++; $display("FAIL evict_100 got addr %h lat %0d word %h want 00000100 6 000000c0", la, lat, w); end
    cpu_req = 1'b1; cpu_addr = 32'h0000_0104;
    #1;
    checks++; if (cpu_valid !== 1'b1 || cpu_rdata !== 32'hC1) begin
      errors++; $display("FAIL evict_refilled got valid %b rdata %h want 1 000000c1", cpu_valid, cpu_rdata); end
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic test_flush_idle();
    logic [31:0] la;
    int lat;
    logic [31:0] w;
    cpu_req = 1'b1; cpu_addr = 32'h0000_010C; flush = 1'b1;
    #1;
    checks++; if (cpu_valid !== 1'b1 || cpu_rdata !== 32'hC3) begin
      errors++; $display("FAIL flush_same_cycle got valid %b rdata %h want 1 000000c3", cpu_valid, cpu_rdata); end
    tick();
    flush = 1'b0; cpu_req = 1'b0;
    refill(32'h0000_0100, 32'hD0, la, lat, w);
    checks++; if (lat != 6 || w !== 32'hD0) begin
      errors++; $display("FAIL flush_idle_miss got lat %0d word %h want 6 000000d0", lat, w); end
  endtask

  task automatic test_flush_fill();
    logic [31:0] la;
    int lat;
    logic [31:0] w;
    cpu_req = 1'b1; cpu_addr = 32'h0000_0218;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hE0 + 32'(i);
      flush = (i == 1);
      tick();
    end
    mem_rvalid = 1'b0; flush = 1'b0;
    #1;
    checks++; if (cpu_valid !== 1'b1 || cpu_rdata !== 32'hE2) begin
      errors++; $display("FAIL flush_fill_resp got valid %b rdata %h want 1 000000e2", cpu_valid, cpu_rdata); end
    tick();
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1;
    #1;
    checks++; if (cpu_stall !== 1'b1 || cpu_valid !== 1'b0) begin
      errors++; $display("FAIL flush_fill_miss got stall %b valid %b want 1 0", cpu_stall, cpu_valid); end
    refill(32'h0000_0218, 32'hF0, la, lat, w);
    checks++; if (lat != 6 || w !== 32'hF2) begin
      errors++; $display("FAIL flush_fill_refill got lat %0d word %h want 6 000000f2", lat, w); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] la;
    int lat;
    logic [31:0] w;
    cpu_req = 1'b1; cpu_addr = 32'h0000_0308;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h90 + 32'(i);
      tick();
    end
    mem_rdata = 32'h92;
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0 || cpu_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_fill got req %b stall %b valid %b want 0 0 0", mem_req, cpu_stall, cpu_valid); end
    tick();
    mem_rdata = 32'h93;
    tick();
    rst = 1'b0; cpu_req = 1'b0;
    mem_rdata = 32'hBAD;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      errors++; $display("FAIL rst_counters got hit %0d miss %0d want 0 0", hit_cnt, miss_cnt); end
    refill(32'h0000_0308, 32'h40, la, lat, w);
    checks++; if (la !== 32'h0000_0300 || lat != 6 || w !== 32'h42) begin
      errors++; $display("FAIL rst_refill got addr %h lat %0d word %h want 00000300 6 00000042", la, lat, w); end
    cpu_req = 1'b1; cpu_addr = 32'h0000_0300;
    #1;
    checks++; if (cpu_valid !== 1'b1 || cpu_rdata !== 32'h40) begin
      errors++; $display("FAIL rst_word0 got valid %b rdata %h want 1 00000040", cpu_valid, cpu_rdata); end
    tick();
    cpu_addr = 32'h0000_030C;
    #1;
    checks++; if (cpu_valid !== 1'b1 || cpu_rdata !== 32'h43) begin
      errors++; $display("FAIL rst_word3 got valid %b rdata %h want 1 00000043", cpu_valid, cpu_rdata); end
    tick();
    cpu_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_hit();
    test_perf();
    test_eviction();
    test_flush_idle();
    test_flush_fill();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
